// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead prefetch FIFO with synchronous flush; each entry holds {instr, pc}.
module instr_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_enq,
  input  logic [W-1:0]  i_data,
  input  logic          i_deq,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_enq;
  logic          w_do_deq;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rd_ptr];
  assign w_do_enq = i_enq & ~o_full;
  assign w_do_deq = i_deq & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides validity,
  // which keeps the array mappable to plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_enq && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs a one-outstanding
// request handshake with instruction memory and buffers hits for Stage D.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int            AW       = 32,
  parameter  int            IW       = 32,
  parameter  int            DEPTH    = 4,
  parameter  logic [AW-1:0] RESET_PC = '0,
  localparam int            CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          instrreq,
  output logic [AW-1:0] instradr,
  input  logic [IW-1:0] instrF,
  input  logic          hit,
  input  logic          abort,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          deq,
  output logic          instr_valid,
  output logic [IW-1:0] instrD,
  output logic [AW-1:0] pcD,
  output logic [AW-1:0] pc4D,
  output logic [CW-1:0] count,
  output logic          full
);

  fetch_state_t        r_state;
  logic                r_squash;
  logic                r_instrreq;
  logic [AW-1:0]       r_instradr;
  logic [AW-1:0]       r_fetch_pc;

  logic                w_resp;
  logic                w_enq;
  logic                w_empty;
  logic                w_full;
  logic                w_deq_eff;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_post_count;
  logic [AW-1:0]       w_next_pc;
  logic [IW+AW-1:0]    w_head;

  // Abort wins over hit when both arrive together.
  assign w_resp       = hit | abort;
  assign w_enq        = (r_state == F_WAIT) & hit & ~abort & ~r_squash & ~redirect;
  assign w_deq_eff    = deq & ~w_empty;
  assign w_post_count = w_count + CW'(1) - CW'(w_deq_eff);
  assign w_next_pc    = r_instradr + AW'(PC_INC);

  instr_fifo #(
    .W     (IW + AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (redirect),
    .i_enq   (w_enq),
    .i_data  ({instrF, r_instradr}),
    .i_deq   (deq),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= F_IDLE;
      r_squash   <= 1'b0;
      r_instrreq <= 1'b0;
      r_instradr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_instrreq <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end else if (!w_full) begin
            r_instrreq <= 1'b1;
            r_instradr <= r_fetch_pc;
            r_state    <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (w_resp) begin
            if (redirect) begin
              r_fetch_pc <= redirect_pc;
              r_squash   <= 1'b0;
              r_state    <= F_IDLE;
            end else if (r_squash) begin
              // Response belonged to the pre-redirect stream; fetch the new target.
              r_squash   <= 1'b0;
              r_instrreq <= 1'b1;
              r_instradr <= r_fetch_pc;
            end else if (abort) begin
              r_instrreq <= 1'b1;
            end else begin
              r_fetch_pc <= w_next_pc;
              if (w_post_count < CW'(DEPTH)) begin
                r_instrreq <= 1'b1;
                r_instradr <= w_next_pc;
              end else begin
                r_state <= F_IDLE;
              end
            end
          end else if (redirect) begin
            r_squash   <= 1'b1;
            r_fetch_pc <= redirect_pc;
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  assign instrreq    = r_instrreq;
  assign instradr    = r_instradr;
  assign instr_valid = ~w_empty;
  assign instrD      = w_head[AW +: IW];
  assign pcD         = w_head[AW-1:0];
  assign pc4D        = w_head[AW-1:0] + AW'(PC_INC);
  assign count       = w_count;
  assign full        = w_full;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined MIPS core, replacing the fixed one-request fetch handshake inside the datapath.
- Owns the fetch PC and drives the instruction-memory request/hit/abort handshake with one outstanding request.
- Buffers returned instructions in a DEPTH-entry prefetch queue feeding Stage D; supports redirect from branch/jump with squash of in-flight responses.

Parameters:
AW, 32, fetch address width
IW, 32, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >=2
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low (asserted at 0)
instrreq  output  1  registered one-cycle request pulse to instruction memory
instradr  output  AW  registered address of outstanding request, stable until its response
instrF  input  IW  instruction data, valid when hit=1
hit  input  1  response: instrF valid this cycle
abort  input  1  response: request dropped, must be reissued
redirect  input  1  branch/jump taken in D; flush and refetch
redirect_pc  input  AW  new fetch address when redirect=1
deq  input  1  Stage D consumes head entry (~StallD)
instr_valid  output  1  queue non-empty
instrD  output  IW  head instruction
pcD  output  AW  head instruction address
pc4D  output  AW  pcD+4, modulo 2^AW
count  output  $clog2(DEPTH)+1  occupancy
full  output  1  count==DEPTH

Behaviour:
- Reset (reset=0, immediate): state F_IDLE, instrreq=0, instradr=RESET_PC, fetch_pc=RESET_PC, squash=0, count=0, queue empty. instrD/pcD are don't-care while instr_valid=0.
- fetch_pc is the next address to issue. Issue means: instrreq<=1, instradr<=issue address, state<=F_WAIT. instrreq is 0 in every other cycle.
- F_IDLE:
  - If redirect: fetch_pc<=redirect_pc, no issue this cycle.
  - Else if count<DEPTH: issue fetch_pc.
  - hit and abort are ignored in F_IDLE, including stale responses after reset release.
- F_WAIT: hit/abort are sampled every cycle, including the cycle instrreq=1. Both asserted at once: treat as abort.
  - hit, squash=0, no redirect:
    - Enqueue {instrF, instradr}; fetch_pc<=instradr+4.
    - If post-update count<DEPTH, issue instradr+4 immediately (back-to-back, 1 instr/cycle); else go to F_IDLE.
  - abort, squash=0, no redirect: reissue the same instradr next cycle (instrreq<=1).
  - Response (hit or abort) with squash=1: discard, squash<=0, issue fetch_pc.
  - Response with redirect in the same cycle: discard, fetch_pc<=redirect_pc, go to F_IDLE.
  - No response, redirect=1: squash<=1, fetch_pc<=redirect_pc, stay in F_WAIT with instradr held.
  - Second redirect while squash=1: update fetch_pc only.
- Redirect priority: clears the queue (count<=0) and overrides deq and enqueue in that cycle.
- Queue:
  - Show-ahead; an entry enqueued at edge t is visible on instrD/pcD after edge t.
  - Simultaneous enq+deq leaves count unchanged; deq while empty is ignored.
  - Enqueue never exceeds DEPTH, because issue requires a free slot and only responses fill the queue.
  - Pointers wrap modulo DEPTH.
- PC arithmetic is modulo 2^AW. Wrap from 2^AW-4 to 0 is legal.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {F_IDLE, F_WAIT}; localparam PC_INC=4.
- Sub-module instr_fifo: width/depth parametrised, synchronous flush, show-ahead read, count/full/empty outputs; entry = {instr, pc}.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset release, memory hits in every cycle instrreq=1 (IW=32, RESET_PC=0), deq=0 -> instradr 0,4,8,12 on consecutive cycles; full=1 and instrreq stays 0 after the 4th hit; pcD=0, pc4D=4.
- From full, pulse deq for 1 cycle -> count 4->3, one request issued to 16; after its hit, count=4 and the new tail pc is 16.
- abort on request to 8, then hit -> instrreq reasserted with instradr=8; queue holds 0,4,8 with no duplicates or gaps.
- Request 12 outstanding, redirect=1 with redirect_pc=0x100, hit two cycles later with instrF=0xDEAD -> 0xDEAD discarded, queue empty, next instrreq has instradr=0x100.
- Redirect in the same cycle as a hit and a deq -> count=0 next cycle, hit data dropped, next issue at redirect_pc.
- reset driven low while in F_WAIT, hit arriving 1 cycle after release -> ignored, first request after release is RESET_PC, count=0.
